mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data and address width; BYTES = XLEN/8.
REQ-002 The block SHALL have parameter BIG_END, default 1, where 1 selects big-endian lane mapping and 0 selects little-endian.
REQ-003 The block SHALL have parameter MISALIGN_SPLIT, default 1, where 1 splits misaligned accesses into two bus words and 0 reports them as errors.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port req_valid / req_ready, input / output, 1 bit each: pipeline request handshake.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 for store, 0 for load.
REQ-008 The block SHALL have port req_funct3, input, 3 bits: RISC-V load/store funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-009 The block SHALL have ports req_addr and req_wdata, input, XLEN bits each: byte address and store data, with store data LSB-aligned.
REQ-010 The block SHALL have ports rsp_valid (output, 1 bit), rsp_rdata (output, XLEN bits) and rsp_err (output, 1 bit): completion, extended load data, and error flag.
REQ-011 The block SHALL have ports bus_req (output, 1), bus_we (output, 1), bus_addr (output, XLEN, word-aligned), bus_wdata (output, XLEN) and bus_be (output, BYTES).
REQ-012 The block SHALL have ports bus_ack (input, 1), bus_err (input, 1) and bus_rdata (input, XLEN).

Function
REQ-013 The state machine SHALL have states IDLE, ACC0, ACC1 and RESP; req_ready SHALL be 1 only in IDLE.
REQ-014 On accept (req_valid & req_ready), the block SHALL latch all request fields, and the next state SHALL be ACC0, or RESP with an error per REQ-020/021.
REQ-015 Lane mapping: the byte at word offset k SHALL use lane k (bits 8k+7:8k) when little-endian and lane BYTES-1-k when big-endian.
REQ-016 In ACC0/ACC1, bus_req SHALL be held high with stable addr/we/wdata/be until bus_ack or bus_err is sampled high; bus_req SHALL be 0 in IDLE and RESP.
REQ-017 An access SHALL be misaligned when it crosses a word boundary: for LH/LHU/SH, offset = BYTES-1; for LW/SW, offset ≠ 0.
REQ-018 For an aligned access, on ack in ACC0 the block SHALL go to RESP.
REQ-019 For a misaligned access, on ack in ACC0 the block SHALL go to ACC1 with bus_addr = word address + BYTES; this address wraps modulo 2^XLEN.
- Each half carries only its own bytes in bus_be/bus_wdata.
- Loads merge both reads into a lower-address-first byte sequence, then apply endianness.
REQ-020 An illegal funct3 SHALL cause no bus access, with RESP and rsp_err=1. Illegal values: loads 011/110/111; stores ≥011.
REQ-021 With MISALIGN_SPLIT=0, a misaligned access SHALL cause no bus access, with RESP and rsp_err=1.
REQ-022 bus_err in ACC0 or ACC1 SHALL abort the access immediately to RESP with rsp_err=1; there is no second access, and a store's first half is not rolled back.
REQ-023 In RESP, rsp_valid SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
- Load data: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
- Stores and errors: rsp_rdata = 0.
REQ-024 Latency with zero-wait ack SHALL be:
- aligned: 3 cycles from accept to rsp_valid;
- split: 4 cycles;
- error: 2 cycles.
REQ-025 Byte enables for stores SHALL be:
- SB: 1 lane;
- SH: 2 lanes;
- SW: all lanes;
- with a split store dividing them between ACC0 and ACC1.

Reset
REQ-026 While rst=1, the state SHALL be IDLE and all outputs SHALL be 0 except req_ready=1, asynchronously, including mid-access; there SHALL be no pending state after release.

Structure
REQ-027 The mem_state_t enum and the LB..SW funct3 constants SHALL live in the shared defines package.
REQ-028 The lane shift, merge and extension logic SHALL be in one sub-module, lane_align, which is purely combinational and parametrised by XLEN and BIG_END.

Verification
REQ-029 Little-endian, LB at 0x103, with bus_rdata 0x8000_0000: a single access at 0x100 with be=1000 SHALL give rsp_rdata 0xFFFF_FF80.
REQ-030 Little-endian, LH at 0x103, with reads 0xAB00_0000 at 0x100 then 0x0000_00CD at 0x104: rsp_rdata SHALL be 0xFFFF_CDAB, 4 cycles after accept.
REQ-031 Little-endian, SW of 0x1234_5678 at 0x102 SHALL produce:
- first write: 0x100, be=1100, wdata 0x5678_0000;
- second write: 0x104, be=0011, wdata 0x0000_1234.
REQ-032 Big-endian, LBU at 0x100 with bus_rdata 0x7F00_0000 SHALL give rsp_rdata 0x0000_007F; LW at 0xFFFF_FFFE SHALL wrap its second access to 0x0000_0000.
REQ-033 Load with funct3=011 SHALL give no bus_req and rsp_err=1 two cycles after accept; with MISALIGN_SPLIT=0, LW at 0x101 SHALL behave the same.
REQ-034 bus_err during ACC1 SHALL give rsp_err=1. Asserting rst while bus_req=1 SHALL drop bus_req in the same cycle and make req_ready=1 after release.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, RISC-V funct3 codes
// and a small decode helper used by the top and the lane aligner.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } mem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return (f3 > F3_SW);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational byte-lane steering: store data/enables for both bus words and
// merge/extension of load data read from one or two bus words.
module lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit BIG_END = 1'b1,
  localparam int BYTES  = XLEN / 8,
  localparam int OFFW   = $clog2(BYTES),
  localparam int SHW    = $clog2(XLEN)
) (
  input  logic [OFFW-1:0]  i_offset,
  input  logic [2:0]       i_funct3,
  input  logic [XLEN-1:0]  i_wdata,
  input  logic [XLEN-1:0]  i_rd0,
  input  logic [XLEN-1:0]  i_rd1,
  output logic [BYTES-1:0] o_be0,
  output logic [BYTES-1:0] o_be1,
  output logic [XLEN-1:0]  o_wdata0,
  output logic [XLEN-1:0]  o_wdata1,
  output logic [XLEN-1:0]  o_rdata
);

  function automatic logic [XLEN-1:0] bswap(input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    r = '0;
    for (int b = 0; b < BYTES; b++) r[8*b +: 8] = d[8*(BYTES-1-b) +: 8];
    return r;
  endfunction

  function automatic logic [BYTES-1:0] brev(input logic [BYTES-1:0] m);
    logic [BYTES-1:0] r;
    r = '0;
    for (int b = 0; b < BYTES; b++) r[b] = m[BYTES-1-b];
    return r;
  endfunction

  logic [SHW-1:0]     w_trim;
  logic [XLEN-1:0]    w_nmask;
  logic [BYTES-1:0]   w_nbmask;
  logic [XLEN-1:0]    w_seq_st;
  logic [2*XLEN-1:0]  w_img_st;
  logic [2*BYTES-1:0] w_bmask;
  logic [2*XLEN-1:0]  w_img_ld;
  logic [XLEN-1:0]    w_val;

  always_comb begin
    w_trim   = '0;
    w_nmask  = '1;
    w_nbmask = '1;
    case (i_funct3[1:0])
      2'b00: begin
        w_trim   = SHW'(XLEN - 8);
        w_nmask  = XLEN'(8'hFF);
        w_nbmask = BYTES'(1);
      end
      2'b01: begin
        w_trim   = SHW'(XLEN - 16);
        w_nmask  = XLEN'(16'hFFFF);
        w_nbmask = BYTES'(3);
      end
      default: begin
        w_trim   = '0;
        w_nmask  = '1;
        w_nbmask = '1;
      end
    endcase
  end

  // Work in address order (byte 0 = lowest address) across a two-word window,
  // then map each word onto bus lanes for the configured endianness.
  assign w_seq_st = BIG_END ? (bswap(i_wdata) >> w_trim) : (i_wdata & w_nmask);
  assign w_img_st = {{XLEN{1'b0}}, w_seq_st} << {i_offset, 3'b000};
  assign w_bmask  = {{BYTES{1'b0}}, w_nbmask} << i_offset;

  assign o_wdata0 = BIG_END ? bswap(w_img_st[XLEN-1:0])    : w_img_st[XLEN-1:0];
  assign o_wdata1 = BIG_END ? bswap(w_img_st[2*XLEN-1:XLEN]) : w_img_st[2*XLEN-1:XLEN];
  assign o_be0    = BIG_END ? brev(w_bmask[BYTES-1:0])     : w_bmask[BYTES-1:0];
  assign o_be1    = BIG_END ? brev(w_bmask[2*BYTES-1:BYTES]) : w_bmask[2*BYTES-1:BYTES];

  assign w_img_ld = {(BIG_END ? bswap(i_rd1) : i_rd1), (BIG_END ? bswap(i_rd0) : i_rd0)}
                    >> {i_offset, 3'b000};
  assign w_val    = BIG_END ? (bswap(w_img_ld[XLEN-1:0]) >> w_trim)
                            : (w_img_ld[XLEN-1:0] & w_nmask);

  always_comb begin
    case (i_funct3)
      F3_LB:   o_rdata = {{(XLEN-8){w_val[7]}}, w_val[7:0]};
      F3_LH:   o_rdata = {{(XLEN-16){w_val[15]}}, w_val[15:0]};
      default: o_rdata = w_val;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between a RISC-V pipeline and a word-wide bus; splits
// word-crossing accesses into two bus transfers or reports them as errors.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit BIG_END        = 1'b1,
  parameter bit MISALIGN_SPLIT = 1'b1,
  localparam int BYTES         = XLEN / 8,
  localparam int OFFW          = $clog2(BYTES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  output logic             rsp_valid,
  output logic [XLEN-1:0]  rsp_rdata,
  output logic             rsp_err,
  output logic             bus_req,
  output logic             bus_we,
  output logic [XLEN-1:0]  bus_addr,
  output logic [XLEN-1:0]  bus_wdata,
  output logic [BYTES-1:0] bus_be,
  input  logic             bus_ack,
  input  logic             bus_err,
  input  logic [XLEN-1:0]  bus_rdata,
  output mem_state_t       dbg_state
);

  mem_state_t       r_state;
  logic             r_we;
  logic [2:0]       r_funct3;
  logic [OFFW-1:0]  r_offset;
  logic [XLEN-1:0]  r_waddr;
  logic [XLEN-1:0]  r_wdata;
  logic             r_split;
  logic             r_err;
  logic [XLEN-1:0]  r_rd0;
  logic [XLEN-1:0]  r_rd1;
  logic             r_rsp_valid;
  logic             r_rsp_err;
  logic [XLEN-1:0]  r_rsp_rdata;

  logic             w_illegal;
  logic             w_misalign;
  logic [BYTES-1:0] w_be0;
  logic [BYTES-1:0] w_be1;
  logic [XLEN-1:0]  w_wd0;
  logic [XLEN-1:0]  w_wd1;
  logic [XLEN-1:0]  w_ldata;
  logic             w_acc0;
  logic             w_acc1;

  assign w_illegal  = f3_illegal(req_we, req_funct3);
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && (req_addr[OFFW-1:0] == '1)) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[OFFW-1:0] != '0));

  lane_align #(
    .XLEN    (XLEN),
    .BIG_END (BIG_END)
  ) u_lane_align (
    .i_offset (r_offset),
    .i_funct3 (r_funct3),
    .i_wdata  (r_wdata),
    .i_rd0    (r_rd0),
    .i_rd1    (r_rd1),
    .o_be0    (w_be0),
    .o_be1    (w_be1),
    .o_wdata0 (w_wd0),
    .o_wdata1 (w_wd1),
    .o_rdata  (w_ldata)
  );

  // Request side: a transfer happens on a rising edge where req_valid and
  // req_ready are both 1; bus side: bus_req holds until bus_ack or bus_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_funct3    <= '0;
      r_offset    <= '0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_split     <= 1'b0;
      r_err       <= 1'b0;
      r_rd0       <= '0;
      r_rd1       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_offset <= req_addr[OFFW-1:0];
            r_waddr  <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
            r_wdata  <= req_wdata;
            r_split  <= w_misalign;
            if (w_illegal || (w_misalign && !MISALIGN_SPLIT)) begin
              r_err   <= 1'b1;
              r_state <= RESP;
            end else begin
              r_err   <= 1'b0;
              r_state <= ACC0;
            end
          end
        end
        ACC0: begin
          if (bus_err) begin
            r_err   <= 1'b1;
            r_state <= RESP;
          end else if (bus_ack) begin
            r_rd0   <= bus_rdata;
            r_state <= r_split ? ACC1 : RESP;
          end
        end
        ACC1: begin
          if (bus_err) begin
            r_err   <= 1'b1;
            r_state <= RESP;
          end else if (bus_ack) begin
            r_rd1   <= bus_rdata;
            r_state <= RESP;
          end
        end
        RESP: begin
          // Response is registered here, so it appears the cycle after RESP.
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= r_err;
          r_rsp_rdata <= (r_err || r_we) ? '0 : w_ldata;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_acc0    = (r_state == ACC0);
  assign w_acc1    = (r_state == ACC1);
  assign req_ready = (r_state == IDLE);
  assign bus_req   = w_acc0 || w_acc1;
  assign bus_we    = bus_req && r_we;
  assign bus_addr  = w_acc0 ? r_waddr : (w_acc1 ? (r_waddr + XLEN'(BYTES)) : '0);
  assign bus_be    = w_acc0 ? w_be0 : (w_acc1 ? w_be1 : '0);
  assign bus_wdata = bus_we ? (w_acc0 ? w_wd0 : w_wd1) : '0;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: three configurations (BE split, LE split, LE no
// split) against a byte-addressed memory model with random bus wait states.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int NI = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;

  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        rsp_valid [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];
  logic        bus_req   [NI];
  logic        bus_we    [NI];
  logic [31:0] bus_addr  [NI];
  logic [31:0] bus_wdata [NI];
  logic [3:0]  bus_be    [NI];
  mem_state_t  dbg_state [NI];

  mem_access_unit #(.XLEN(32), .BIG_END(1'b1), .MISALIGN_SPLIT(1'b1)) u_dut_be (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .bus_req(bus_req[0]), .bus_we(bus_we[0]), .bus_addr(bus_addr[0]), .bus_wdata(bus_wdata[0]),
    .bus_be(bus_be[0]), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata),
    .dbg_state(dbg_state[0])
  );

  mem_access_unit #(.XLEN(32), .BIG_END(1'b0), .MISALIGN_SPLIT(1'b1)) u_dut_le (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .bus_req(bus_req[1]), .bus_we(bus_we[1]), .bus_addr(bus_addr[1]), .bus_wdata(bus_wdata[1]),
    .bus_be(bus_be[1]), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata),
    .dbg_state(dbg_state[1])
  );

  mem_access_unit #(.XLEN(32), .BIG_END(1'b0), .MISALIGN_SPLIT(1'b0)) u_dut_ns (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]),
    .bus_req(bus_req[2]), .bus_we(bus_we[2]), .bus_addr(bus_addr[2]), .bus_wdata(bus_wdata[2]),
    .bus_be(bus_be[2]), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata),
    .dbg_state(dbg_state[2])
  );

  // ---------------- scoreboard state ----------------
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  logic [7:0] mem     [logic [31:0]];
  logic [7:0] exp_mem [logic [31:0]];

  int          acc_n;
  logic [31:0] acc_addr  [4];
  logic [3:0]  acc_be    [4];
  logic [31:0] acc_wdata [4];
  logic        acc_we    [4];
  bit          got_rsp;
  int          got_lat;
  logic [31:0] got_rdata;
  logic        got_err;
  int          waits_total;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit is_be(input int inst);
    return inst == 0;
  endfunction

  function automatic bit can_split(input int inst);
    return inst != 2;
  endfunction

  function automatic logic [7:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a[7:0] ^ 8'h5A);
  endfunction

  function automatic logic [7:0] rd_exp(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : (a[7:0] ^ 8'h5A);
  endfunction

  // Byte address that sits on bus lane l of the word at w.
  function automatic logic [31:0] lane_addr(input int inst, input logic [31:0] w, input int l);
    return w + (is_be(inst) ? 32'(3 - l) : 32'(l));
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    mem[a]     = b;
    exp_mem[a] = b;
  endtask

  // ---------------- driver + bus responder ----------------
  task automatic run_txn(input int inst, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int err_at, input int max_wait);
    int          wait_left;
    bit          new_acc;
    int          idx;
    logic [31:0] word;
    logic [31:0] a;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid[inst] = 1'b1;
    check("req_ready_idle", 32'(req_ready[inst]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[inst] = 1'b0;
    acc_n = 0; got_rsp = 0; waits_total = 0; new_acc = 1; wait_left = 0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
      if (rsp_valid[inst]) begin
        got_rsp = 1; got_lat = cyc; got_rdata = rsp_rdata[inst]; got_err = rsp_err[inst];
        break;
      end
      if (bus_req[inst]) begin
        if (new_acc) begin
          if (acc_n < 4) begin
            acc_addr[acc_n] = bus_addr[inst]; acc_be[acc_n] = bus_be[inst];
            acc_wdata[acc_n] = bus_wdata[inst]; acc_we[acc_n] = bus_we[inst];
          end
          acc_n++;
          new_acc = 0;
          wait_left = int'($urandom_range(max_wait, 0));
        end else begin
          idx = (acc_n > 4) ? 3 : acc_n - 1;
          check("bus_stable_addr", bus_addr[inst], acc_addr[idx]);
          check("bus_stable_be", 32'(bus_be[inst]), 32'(acc_be[idx]));
          check("bus_stable_wdata", bus_wdata[inst], acc_wdata[idx]);
        end
        if (wait_left == 0) begin
          if (acc_n == err_at) begin
            bus_err = 1'b1;
          end else begin
            bus_ack = 1'b1;
            word = bus_addr[inst];
            for (int l = 0; l < 4; l++) begin
              a = lane_addr(inst, word, l);
              bus_rdata[8*l +: 8] = rd_mem(a);
              if (bus_we[inst] && bus_be[inst][l]) mem[a] = bus_wdata[inst][8*l +: 8];
            end
          end
          new_acc = 1;
        end else begin
          wait_left--;
          waits_total++;
        end
      end
      @(negedge clk);
    end
    bus_ack = 1'b0; bus_err = 1'b0;
    check("rsp_seen", 32'(got_rsp), 32'd1);
    if (got_rsp) begin
      @(negedge clk);
      check("rsp_one_cycle", 32'(rsp_valid[inst]), 32'd0);
    end
  endtask

  // ---------------- reference model + checks ----------------
  task automatic txn_check(input int inst, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int err_at, input int max_wait);
    int          n, off, planned, exp_seen, ok_done, kacc;
    bit          illegal, crosses, pre_err, bus_abort, exp_errf;
    logic [31:0] v, exp_rdata, word0, wk, ba, a, exp_be;
    logic [7:0]  b;
    n        = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off      = int'(addr[1:0]);
    crosses  = (off + n) > 4;
    illegal  = we ? (f3 >= 3'b011) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    pre_err  = illegal || (crosses && !can_split(inst));
    planned  = pre_err ? 0 : (crosses ? 2 : 1);
    bus_abort = (err_at > 0) && (err_at <= planned);
    exp_seen = bus_abort ? err_at : planned;
    ok_done  = bus_abort ? err_at - 1 : planned;
    exp_errf = pre_err || bus_abort;
    word0    = {addr[31:2], 2'b00};

    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      b = rd_exp(addr + 32'(i));
      if (is_be(inst)) v = (v << 8) | 32'(b);
      else             v = v | (32'(b) << (8 * i));
    end
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    exp_rdata = (exp_errf || we) ? 32'h0 : v;
    exp_q.push_back(exp_rdata);

    run_txn(inst, we, f3, addr, wdata, err_at, max_wait);

    exp_rdata = exp_q.pop_front();
    if (got_rsp) begin
      check("rsp_latency", 32'(got_lat), pre_err ? 32'd2 : 32'(exp_seen + 2 + waits_total));
      check("rsp_err", 32'(got_err), 32'(exp_errf));
      check("rsp_rdata", got_rdata, exp_rdata);
    end
    check("bus_access_count", 32'(acc_n), 32'(exp_seen));
    for (int k = 0; k < 2; k++) begin
      if (k < exp_seen && k < acc_n) begin
        wk = word0 + 32'(4 * k);
        exp_be = 32'h0;
        for (int l = 0; l < 4; l++) begin
          ba = lane_addr(inst, wk, l);
          if ((ba - addr) < 32'(n)) exp_be[l] = 1'b1;
        end
        check("bus_addr", acc_addr[k], wk);
        check("bus_be", 32'(acc_be[k]), exp_be);
        check("bus_we", 32'(acc_we[k]), 32'(we));
      end
    end

    if (we) begin
      for (int i = 0; i < n; i++) begin
        a = addr + 32'(i);
        kacc = ({a[31:2], 2'b00} == word0) ? 0 : 1;
        if (kacc < ok_done)
          exp_mem[a] = 8'(wdata >> (8 * (is_be(inst) ? (n - 1 - i) : i)));
      end
      for (int i = -1; i <= n; i++) begin
        a = addr + 32'(i);
        check("mem_byte", 32'(rd_mem(a)), 32'(rd_exp(a)));
      end
    end
  endtask

  // ---------------- stimulus ----------------
  logic [2:0]  ld_tab [5];
  logic [31:0] r_addr;
  logic [2:0]  r_f3;
  logic        r_we;
  int          r_errat;

  initial begin
    ld_tab[0] = F3_LB; ld_tab[1] = F3_LH; ld_tab[2] = F3_LW; ld_tab[3] = F3_LBU; ld_tab[4] = F3_LHU;
    rst = 1'b1;
    req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
    for (int i = 0; i < NI; i++) req_valid[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_req_ready", 32'(req_ready[i]), 32'd1);
      check("rst_bus_req", 32'(bus_req[i]), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      check("rst_rsp_rdata", rsp_rdata[i], 32'd0);
      check("rst_bus_be", 32'(bus_be[i]), 32'd0);
      check("rst_state", 32'(dbg_state[i]), 32'(IDLE));
    end
    rst = 1'b0;

    // LE LB at 0x103 reading 0x8000_0000
    poke(32'h100, 8'h00); poke(32'h101, 8'h00); poke(32'h102, 8'h00); poke(32'h103, 8'h80);
    txn_check(1, 1'b0, F3_LB, 32'h103, 32'h0, 0, 0);
    check("le_lb_rdata", got_rdata, 32'hFFFF_FF80);
    check("le_lb_addr", acc_addr[0], 32'h100);
    check("le_lb_be", 32'(acc_be[0]), 32'h8);

    // LE LH at 0x103 split across 0x100 / 0x104
    poke(32'h103, 8'hAB); poke(32'h104, 8'hCD);
    poke(32'h105, 8'h00); poke(32'h106, 8'h00); poke(32'h107, 8'h00);
    txn_check(1, 1'b0, F3_LH, 32'h103, 32'h0, 0, 0);
    check("le_lh_rdata", got_rdata, 32'hFFFF_CDAB);
    check("le_lh_latency", 32'(got_lat), 32'd4);

    // LE SW of 0x1234_5678 at 0x102
    txn_check(1, 1'b1, F3_SW, 32'h102, 32'h1234_5678, 0, 0);
    check("le_sw_addr0", acc_addr[0], 32'h100);
    check("le_sw_be0", 32'(acc_be[0]), 32'hC);
    check("le_sw_wdata0", acc_wdata[0], 32'h5678_0000);
    check("le_sw_addr1", acc_addr[1], 32'h104);
    check("le_sw_be1", 32'(acc_be[1]), 32'h3);
    check("le_sw_wdata1", acc_wdata[1], 32'h0000_1234);

    // BE LBU at 0x100 and LW wrapping past the top of the address space
    poke(32'h100, 8'h7F); poke(32'h101, 8'h00); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
    txn_check(0, 1'b0, F3_LBU, 32'h100, 32'h0, 0, 0);
    check("be_lbu_rdata", got_rdata, 32'h0000_007F);
    txn_check(0, 1'b0, F3_LW, 32'hFFFF_FFFE, 32'h0, 0, 1);
    check("be_lw_wrap_addr1", acc_addr[1], 32'h0000_0000);

    // Illegal funct3 and unsplittable misaligned access
    txn_check(0, 1'b0, 3'b011, 32'h100, 32'h0, 0, 0);
    check("illegal_err", 32'(got_err), 32'd1);
    check("illegal_no_bus", 32'(acc_n), 32'd0);
    txn_check(2, 1'b0, F3_LW, 32'h101, 32'h0, 0, 0);
    check("nosplit_err", 32'(got_err), 32'd1);
    check("nosplit_latency", 32'(got_lat), 32'd2);

    // Bus errors in the second half of split load and store
    txn_check(1, 1'b0, F3_LW, 32'h102, 32'h0, 2, 1);
    check("acc1_buserr", 32'(got_err), 32'd1);
    txn_check(0, 1'b1, F3_SW, 32'h201, 32'hA1B2_C3D4, 2, 0);

    // Reset in the middle of a bus access
    @(negedge clk);
    req_we = 1'b0; req_funct3 = F3_LW; req_addr = 32'h100; req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("midrst_bus_req_before", 32'(bus_req[0]), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_bus_req_async", 32'(bus_req[0]), 32'd0);
    check("midrst_ready_async", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", 32'(req_ready[0]), 32'd1);
    check("midrst_no_rsp", 32'(rsp_valid[0]), 32'd0);
    check("midrst_no_bus", 32'(bus_req[0]), 32'd0);
    txn_check(0, 1'b0, F3_LW, 32'h104, 32'h0, 0, 0);

    // Randomized traffic on all three configurations
    for (int inst = 0; inst < NI; inst++) begin
      for (int t = 0; t < 60; t++) begin
        r_we = 1'($urandom_range(1, 0));
        if ($urandom_range(9, 0) == 0) r_f3 = 3'($urandom_range(7, 0));
        else if (r_we)                 r_f3 = 3'($urandom_range(2, 0));
        else                           r_f3 = ld_tab[$urandom_range(4, 0)];
        if ($urandom_range(7, 0) == 0) r_addr = 32'hFFFF_FFF8 + 32'($urandom_range(7, 0));
        else                           r_addr = 32'h200 + 32'($urandom_range(15, 0));
        r_errat = ($urandom_range(9, 0) == 0) ? int'($urandom_range(2, 1)) : 0;
        txn_check(inst, r_we, r_f3, r_addr, $urandom, r_errat, 2);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
